// File: rtl/aes_round_sequencer_if.sv
// Plaintext-in / ciphertext-out valid/ready streams of the AES round sequencer.
interface aes_round_sequencer_if;
  localparam int unsigned DW = 128;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES-encryption round controller: holds one block, steps it through
// Nr+1 rounds of an external combinational datapath, then offers the ciphertext.
module aes_round_sequencer #(
  parameter int unsigned Nr = 10,
  parameter int unsigned Nk = 4,
  parameter int unsigned RW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_round_sequencer_if.slave bus,
  output logic [127:0]         dp_state,
  output logic [RW-1:0]        rk_idx,
  input  logic [127:0]         first_res,
  input  logic [127:0]         mid_res,
  input  logic [127:0]         last_res,
  output logic                 busy
);

  localparam int unsigned DW = 128;

  if ((Nr != Nk + 6) || ((1 << RW) <= Nr)) begin : g_bad_cfg
    $error("aes_round_sequencer: illegal Nr/Nk/RW combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [DW-1:0] state_q, state_d;
  logic [RW-1:0] round_q, round_d;

  // State register together with the block and round registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Next-state: only the bus selected by the current round reaches the state.
  always_comb begin
    fsm_d   = IDLE;
    state_d = state_q;
    round_d = round_q;
    case (fsm_q)
      IDLE: begin
        fsm_d = IDLE;
        if (bus.in_valid) begin
          fsm_d   = RUN;
          state_d = bus.in_data;
          round_d = '0;
        end
      end
      RUN: begin
        fsm_d = RUN;
        if (round_q == '0) begin
          state_d = first_res;
          round_d = RW'(1);
        end else if (round_q >= RW'(Nr)) begin
          fsm_d   = DONE;
          state_d = last_res;
          round_d = '0;
        end else begin
          state_d = mid_res;
          round_d = round_q + RW'(1);
        end
      end
      DONE: begin
        fsm_d = bus.out_ready ? IDLE : DONE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered FSM state only.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (fsm_q)
      IDLE:    bus.in_ready  = 1'b1;
      RUN:     busy          = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: bus.in_ready  = 1'b0;
    endcase
    bus.out_data = state_q;
    dp_state     = state_q;
    rk_idx       = round_q;
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: behavioural AES round datapath around two builds
// (AES-128 and AES-256), checked against FIPS-197 vectors and directed timing.
module tb_aes_round_sequencer;

  localparam logic [127:0] PT1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT2   = 128'hdeadbeef0123456789abcdeff0e1d2c3;
  localparam logic [255:0] KEY10 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY14 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_round_sequencer_if bus10 ();
  aes_round_sequencer_if bus14 ();

  logic [127:0] dp10, first10, mid10, last10;
  logic [127:0] dp14, first14, mid14, last14;
  logic [3:0]   idx10, idx14;
  logic         busy10, busy14;
  logic [127:0] rk10 [0:15];
  logic [127:0] rk14 [0:15];

  aes_round_sequencer #(.Nr(10), .Nk(4), .RW(4)) dut10 (
    .clk(clk), .rst(rst), .bus(bus10), .dp_state(dp10), .rk_idx(idx10),
    .first_res(first10), .mid_res(mid10), .last_res(last10), .busy(busy10));

  aes_round_sequencer #(.Nr(14), .Nk(8), .RW(4)) dut14 (
    .clk(clk), .rst(rst), .bus(bus14), .dp_state(dp14), .rk_idx(idx14),
    .first_res(first14), .mid_res(mid14), .last_res(last14), .busy(busy14));

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sb(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  // FIPS-197 key expansion; returns round key r.
  function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int r);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 60; i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          rc = 8'h01;
          for (int j = 1; j < i / nk; j++) rc = xt(rc);
          t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [255:0] key,
                                               input int nk, input int nr);
    logic [127:0] s;
    s = pt ^ round_key(key, nk, 0);
    for (int r = 1; r < nr; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ round_key(key, nk, r);
    return shift_rows(sub_bytes(s)) ^ round_key(key, nk, nr);
  endfunction

  always_comb begin
    first10 = dp10 ^ rk10[idx10];
    mid10   = mix_columns(shift_rows(sub_bytes(dp10))) ^ rk10[idx10];
    last10  = shift_rows(sub_bytes(dp10)) ^ rk10[idx10];
    first14 = dp14 ^ rk14[idx14];
    mid14   = mix_columns(shift_rows(sub_bytes(dp14))) ^ rk14[idx14];
    last14  = shift_rows(sub_bytes(dp14)) ^ rk14[idx14];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid on the AES-128 build; edges counts from the accept edge (=1).
  task automatic wait_done10(inout int edges);
    while (!bus10.out_valid && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  int edges;
  int busy_cnt;
  logic [127:0] ct2;

  initial begin
    for (int r = 0; r < 16; r++) begin
      rk10[r] = (r <= 10) ? round_key(KEY10, 4, r) : '0;
      rk14[r] = (r <= 14) ? round_key(KEY14, 8, r) : '0;
    end
    ct2 = aes_encrypt(PT2, KEY10, 4, 10);
    rst = 1'b1;
    bus10.in_valid = 1'b0; bus10.in_data = '0; bus10.out_ready = 1'b0;
    bus14.in_valid = 1'b0; bus14.in_data = '0; bus14.out_ready = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_in_ready", 128'(bus10.in_ready), 128'(1));
    check("rst_busy", 128'(busy10), 128'(0));
    check("rst_out_valid", 128'(bus10.out_valid), 128'(0));
    check("rst_out_data", bus10.out_data, '0);
    check("rst_rk_idx", 128'(idx10), 128'(0));
    rst = 1'b0;
    tick();

    // C.1 vector with rk_idx trace and latency
    bus10.in_data = PT1; bus10.in_valid = 1'b1;
    tick();
    bus10.in_valid = 1'b0; bus10.in_data = '0;
    edges = 1;
    busy_cnt = 0;
    for (int k = 0; k <= 10; k++) begin
      check("run_rk_idx", 128'(idx10), 128'(k));
      check("run_flags", {125'(0), busy10, bus10.in_ready, bus10.out_valid}, {125'(0), 3'b100});
      if (busy10) busy_cnt++;
      tick();
      edges++;
    end
    check("busy_cycles", 128'(busy_cnt), 128'(11));
    check("c1_latency", 128'(edges), 128'(12));
    check("c1_done_flags", {125'(0), busy10, bus10.in_ready, bus10.out_valid}, {125'(0), 3'b001});
    check("c1_ciphertext", bus10.out_data, CT128);

    // Backpressure in DONE with stray in_valid pulses
    for (int k = 0; k < 5; k++) begin
      bus10.in_valid = k[0]; bus10.in_data = PT2;
      tick();
      check("bp_flags", {126'(0), bus10.in_ready, bus10.out_valid}, {126'(0), 2'b01});
      check("bp_out_data", bus10.out_data, CT128);
    end
    bus10.in_valid = 1'b0; bus10.out_ready = 1'b1;
    tick();
    bus10.out_ready = 1'b0;
    check("bp_release_flags", {126'(0), bus10.in_ready, bus10.out_valid}, {126'(0), 2'b10});
    check("idle_out_data_hold", bus10.out_data, CT128);
    tick();
    check("idle_stays_idle", {125'(0), busy10, bus10.in_ready, bus10.out_valid}, {125'(0), 3'b010});

    // Back-to-back blocks with in_valid and out_ready held high
    bus10.in_data = PT1; bus10.in_valid = 1'b1; bus10.out_ready = 1'b1;
    tick();
    bus10.in_data = PT2;
    edges = 1;
    wait_done10(edges);
    check("b2b_first_latency", 128'(edges), 128'(12));
    check("b2b_first_ct", bus10.out_data, CT128);
    tick();
    check("b2b_idle_gap", {125'(0), busy10, bus10.in_ready, bus10.out_valid}, {125'(0), 3'b010});
    tick();
    check("b2b_second_accept", 128'(busy10), 128'(1));
    edges = 1;
    wait_done10(edges);
    bus10.in_valid = 1'b0;
    check("b2b_second_latency", 128'(edges), 128'(12));
    check("b2b_second_ct", bus10.out_data, ct2);
    tick();
    bus10.out_ready = 1'b0;
    check("b2b_end_idle", {126'(0), bus10.in_ready, bus10.out_valid}, {126'(0), 2'b10});

    // Reset at round 5 aborts the block
    bus10.in_data = PT2; bus10.in_valid = 1'b1;
    tick();
    bus10.in_valid = 1'b0;
    repeat (5) tick();
    check("abort_rk_idx", 128'(idx10), 128'(5));
    rst = 1'b1;
    #1;
    check("abort_flags", {125'(0), busy10, bus10.in_ready, bus10.out_valid}, {125'(0), 3'b010});
    check("abort_state", dp10, '0);
    check("abort_rk_idx0", 128'(idx10), 128'(0));
    #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_no_valid", {126'(0), bus10.in_ready, bus10.out_valid}, {126'(0), 2'b10});
    end
    bus10.in_data = PT1; bus10.in_valid = 1'b1;
    tick();
    bus10.in_valid = 1'b0;
    edges = 1;
    wait_done10(edges);
    check("post_abort_latency", 128'(edges), 128'(12));
    check("post_abort_ct", bus10.out_data, CT128);
    bus10.out_ready = 1'b1;
    tick();
    bus10.out_ready = 1'b0;

    // AES-256 build, C.3 vector
    bus14.in_data = PT1; bus14.in_valid = 1'b1;
    tick();
    bus14.in_valid = 1'b0;
    edges = 1;
    busy_cnt = 0;
    while (!bus14.out_valid && edges < 60) begin
      if (busy14) busy_cnt++;
      tick();
      edges++;
    end
    check("c3_busy_cycles", 128'(busy_cnt), 128'(15));
    check("c3_latency", 128'(edges), 128'(16));
    check("c3_ciphertext", bus14.out_data, CT256);
    bus14.out_ready = 1'b1;
    tick();
    bus14.out_ready = 1'b0;
    check("c3_release", {126'(0), bus14.in_ready, bus14.out_valid}, {126'(0), 2'b10});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
